ti_and_pipe: RTL and testbench
==============================

# ti_and_pipe

Pipelined, elastic, three-share threshold-implementation (TI) AND gadget for first-order masked datapaths. The combinational TI AND equations are generalised to a parametrised WIDTH and followed by a configurable-depth register pipeline. Each output share is registered separately, which provides the glitch barrier TI requires between nonlinear layers. A valid/ready handshake lets the block sit between masked S-box stages without external stall logic.

## Interface
- WIDTH, 8, bit width of every share.
- STAGES, 1, pipeline register stages, legal range 1..4. Stage 1 is the mandatory TI glitch barrier.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input shares are valid.
- in_ready  out  1  block accepts input this cycle.
- x0, x1, x2  in  WIDTH  shares of operand x (x = x0^x1^x2).
- y0, y1, y2  in  WIDTH  shares of operand y.
- r0, r1  in  WIDTH  fresh randomness. Present only when TI_AND_REFRESH_EN is defined.
- out_valid  out  1  output shares are valid.
- out_ready  in  1  downstream accepts output.
- q0, q1, q2  out  WIDTH  output shares, with q0^q1^q2 = x&y.

## Operation
- Component functions, bitwise:
  - q0' = x0y0 ^ x0y1 ^ x1y0
  - q1' = x1y1 ^ x2y1 ^ x1y2
  - q2' = x2y2 ^ x2y0 ^ x0y2
- Non-completeness: share i uses only indices i and i+1 (mod 3). No component function may combine all three share indices before the stage-1 register.
- Stage 1 registers q0', q1', q2' (refreshed if enabled). Stages 2..STAGES copy the shares forward unchanged.
- Each stage holds a valid bit v[k].
- A stage loads when it is empty or when its contents move downstream this cycle.
- Data registers load only on an accepted transfer and hold otherwise. No share register toggles on bubbles.
- in_ready = !v[1] || (stage 1 advances). The ready chain back from out_ready is combinational.
- out_valid = v[STAGES]. q0..q2 are the last-stage registers.
- Transfer rules:
  - Input transfer occurs on in_valid && in_ready.
  - Output transfer occurs on out_valid && out_ready.
  - While in_valid && !in_ready, upstream holds the shares stable.
- Ordering is strictly FIFO. No reordering and no drop.

## Timing
- Reset (asynchronous, rst_n low): all v[k]=0, all share registers 0, out_valid=0, q0=q1=q2=0. in_ready=1 from the first cycle after deassertion.
- Latency: an input accepted at edge n appears on q with out_valid=1 after edge n+STAGES-1, i.e. STAGES cycles.
- Throughput: one transfer per cycle when out_ready=1 continuously.
- Full pipeline with out_ready=1: input accept and output emit happen in the same cycle, and in_ready stays 1.
- Full pipeline with out_ready=0: in_ready=0, all registers hold, and q stays stable while out_valid=1.
- Empty pipeline: out_valid=0 and q holds its last value (0 after reset).
- Reset mid-operation: in-flight data is discarded and the block returns to the reset state immediately, without waiting for a clock edge.

## Configuration
- TI_AND_REFRESH_EN defined:
  - r0 and r1 ports exist.
  - Stage 1 captures q0'^r0, q1'^r1, q2'^r0^r1. The unmasked value is unchanged.
  - Randomness is sampled only on an input transfer.
- TI_AND_REFRESH_EN undefined:
  - No r ports.
  - Stage 1 captures q0', q1', q2' directly.
  - Output shares are non-uniform; the integrator must remask downstream.

## Structure
- Package ti_pkg holds:
  - NUM_SHARES = 3.
  - STAGES_MAX = 4.
  - A parametrised share-vector typedef.
  - A function share_idx(i, k) returning (i+k) mod 3.
- Sub-module ti_and_component (combinational, WIDTH-parametrised): inputs xi, xj, yi, yj; output xi&yi ^ xi&yj ^ xj&yi. It is instantiated three times with index pairs (0,1), (1,2), (2,0), which makes non-completeness structural.
- The top level contains the handshake and pipeline registers.

## Test plan
- Basic (STAGES=1, WIDTH=8):
  - Stimulus: x0=0x3C, x1=0x5A, x2=0xC3 (x=0xA5); y0=0xF0, y1=0x33, y2=0xCC (y=0x0F).
  - Response: one cycle later out_valid=1 and q0^q1^q2=0x05.
- Throughput (STAGES=3): stream 16 random operand pairs with out_ready=1. Outputs appear starting 3 cycles after the first accept, one per cycle, in order, each XOR-reconstructing to x&y.
- Back-pressure (STAGES=2):
  - Stimulus: hold out_ready=0 and offer 3 items.
  - Response: 2 accepted, then in_ready=0; q stable. Raising out_ready drains the items in order and accepts the 3rd in the same cycle as the first emit.
- Reset: assert rst_n=0 mid-stream with a full pipeline. out_valid and q go 0 immediately, and in_ready=1 after release.
- Non-completeness: toggle only x2 and y2 while holding x0, x1, y0, y1. The q0' component input to stage 1 does not change.
- Refresh (TI_AND_REFRESH_EN):
  - Stimulus: basic operands with r0=0xFF, r1=0x00.
  - Response: q0 equals the unrefreshed q0 inverted, q1 is unchanged, q2 is inverted, and q0^q1^q2=0x05.

Source files
------------

// File: rtl/ti_and_pipe_pkg.sv
// ti_pkg: shared constants and helpers for the three-share TI AND pipeline.
//   NUM_SHARES  - number of Boolean shares per operand (fixed at 3)
//   STAGES_MAX  - deepest supported register pipeline
//   share_vec_t - share vector at the default width
//   share_idx   - (i+k) mod 3, used to wire component i to shares i and i+1
package ti_pkg;

  localparam int NUM_SHARES    = 3;
  localparam int STAGES_MAX    = 4;
  localparam int WIDTH_DEFAULT = 8;

  // Share vector at the default width; blocks of other widths declare the
  // same shape locally with their own WIDTH.
  typedef logic [NUM_SHARES-1:0][WIDTH_DEFAULT-1:0] share_vec_t;

  function automatic int share_idx(input int i, input int k);
    return (i + k) % NUM_SHARES;
  endfunction

endpackage

// File: rtl/ti_and_pipe_component.sv
// ti_and_component: one TI AND component function, bitwise over WIDTH bits.
//   xi, yi - shares of index i
//   xj, yj - shares of index i+1 (mod 3)
//   z      - xi&yi ^ xi&yj ^ xj&yi
// Only two share indices enter this module, so non-completeness holds by
// construction at every instance.
module ti_and_component #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] xi,
  input  logic [WIDTH-1:0] xj,
  input  logic [WIDTH-1:0] yi,
  input  logic [WIDTH-1:0] yj,
  output logic [WIDTH-1:0] z
);

  assign z = (xi & yi) ^ (xi & yj) ^ (xj & yi);

endmodule

// File: rtl/ti_and_pipe.sv
// ti_and_pipe: elastic three-share threshold-implementation AND gadget.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - input handshake for shares x0..x2, y0..y2
//   r0, r1               - fresh randomness (only with TI_AND_REFRESH_EN)
//   out_valid / out_ready- output handshake for shares q0..q2
// q0^q1^q2 = (x0^x1^x2) & (y0^y1^y2), STAGES cycles after acceptance.
// Optional feature macro: TI_AND_REFRESH_EN (remask stage-1 shares with r0/r1).
module ti_and_pipe
  import ti_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] y1,
  input  logic [WIDTH-1:0] y2,
`ifdef TI_AND_REFRESH_EN
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] r1,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2
);

  localparam int NS = (STAGES < 1) ? 1 : ((STAGES > STAGES_MAX) ? STAGES_MAX : STAGES);

  typedef logic [NUM_SHARES-1:0][WIDTH-1:0] shares_t;

  shares_t x_s, y_s, comp, st1_d;
  assign x_s = {x2, x1, x0};
  assign y_s = {y2, y1, y0};

  // Component i sees shares i and i+1 only.
  for (genvar i = 0; i < NUM_SHARES; i++) begin : g_comp
    localparam int I = share_idx(i, 0);
    localparam int J = share_idx(i, 1);
    ti_and_component #(.WIDTH(WIDTH)) u_comp (
      .xi(x_s[I]), .xj(x_s[J]), .yi(y_s[I]), .yj(y_s[J]), .z(comp[i])
    );
  end

`ifdef TI_AND_REFRESH_EN
  // r0^r1^(r0^r1) = 0, so the unmasked value is preserved.
  assign st1_d[0] = comp[0] ^ r0;
  assign st1_d[1] = comp[1] ^ r1;
  assign st1_d[2] = comp[2] ^ r0 ^ r1;
`else
  assign st1_d = comp;
`endif

  logic [NS:1] vld_pipe_q;
  logic [NS:1] vld_src;
  logic [NS:1] rdy;
  shares_t     pipe_q [1:NS];
  shares_t     pipe_src [1:NS];

  // Stage k may load unless it and every stage after it are full while the
  // sink stalls; written flat so the ready chain has no self-dependency.
  for (genvar k = 1; k <= NS; k++) begin : g_rdy
    assign rdy[k] = out_ready || !(&vld_pipe_q[NS:k]);
  end

  always_comb begin
    vld_src     = '0;
    vld_src[1]  = in_valid;
    pipe_src[1] = st1_d;
    for (int k = 2; k <= NS; k++) begin
      vld_src[k]  = vld_pipe_q[k-1];
      pipe_src[k] = pipe_q[k-1];
    end
  end

  // Share registers only capture on a real transfer, so bubbles never
  // toggle them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      for (int k = 1; k <= NS; k++) pipe_q[k] <= '0;
    end else begin
      for (int k = 1; k <= NS; k++) begin
        if (rdy[k]) begin
          vld_pipe_q[k] <= vld_src[k];
          if (vld_src[k]) pipe_q[k] <= pipe_src[k];
        end
      end
    end
  end

  assign in_ready  = rdy[1];
  assign out_valid = vld_pipe_q[NS];
  assign q0        = pipe_q[NS][0];
  assign q1        = pipe_q[NS][1];
  assign q2        = pipe_q[NS][2];

endmodule

// File: tb/tb_ti_and_pipe.sv
// tb_ti_and_pipe: self-checking bench for ti_and_pipe (STAGES=3, WIDTH=8).
// Reference model: a queue of accepted operand sets with the stage each one
// currently occupies; outputs are the AND of the reconstructed operands.
module tb_ti_and_pipe;

  localparam int W  = 8;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] x0, x1, x2, y0, y1, y2, r0, r1, q0, q1, q2;

  always #5 clk = ~clk;

  ti_and_pipe #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .x1(x1), .x2(x2), .y0(y0), .y1(y1), .y2(y2),
`ifdef TI_AND_REFRESH_EN
    .r0(r0), .r1(r1),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .q0(q0), .q1(q1), .q2(q2)
  );

  typedef struct packed {
    logic [W-1:0] x0, x1, x2, y0, y1, y2, r0, r1;
  } item_t;

  item_t        mq[$];
  int           pos[$];
  item_t        cur;
  logic [23:0]  last_q;
  int           passed = 0;
  int           total  = 0;
  int           failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected output shares straight from the component equations.
  function automatic logic [23:0] exp_shares(input item_t it);
    logic [W-1:0] a, b, c;
    a = (it.x0 & it.y0) ^ (it.x0 & it.y1) ^ (it.x1 & it.y0);
    b = (it.x1 & it.y1) ^ (it.x2 & it.y1) ^ (it.x1 & it.y2);
    c = (it.x2 & it.y2) ^ (it.x2 & it.y0) ^ (it.x0 & it.y2);
`ifdef TI_AND_REFRESH_EN
    a = a ^ it.r0;
    b = b ^ it.r1;
    c = c ^ it.r0 ^ it.r1;
`endif
    return {c, b, a};
  endfunction

  task automatic drive(input item_t it);
    cur = it;
    x0 = it.x0; x1 = it.x1; x2 = it.x2;
    y0 = it.y0; y1 = it.y1; y2 = it.y2;
    r0 = it.r0; r1 = it.r1;
  endtask

  function automatic item_t rnd_item();
    item_t it;
    it = {$urandom, $urandom};
    return it;
  endfunction

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic cycle(output bit acc);
    bit          exp_ir, exp_ov, emit;
    logic [W-1:0] xv, yv;
    @(negedge clk);
    exp_ir = (mq.size() < ST) || out_ready;
    exp_ov = (mq.size() > 0) && (pos[0] == ST);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    if (exp_ov) begin
      xv = mq[0].x0 ^ mq[0].x1 ^ mq[0].x2;
      yv = mq[0].y0 ^ mq[0].y1 ^ mq[0].y2;
      chk("q_xor", {24'd0, q0 ^ q1 ^ q2}, {24'd0, xv & yv});
      chk("q_shares", {8'd0, q2, q1, q0}, {8'd0, exp_shares(mq[0])});
    end else begin
      chk("q_hold", {8'd0, q2, q1, q0}, {8'd0, last_q});
    end
    acc  = in_valid && exp_ir;
    emit = exp_ov && out_ready;
    @(posedge clk);
    if (emit) begin
      last_q = exp_shares(mq[0]);
      void'(mq.pop_front());
      void'(pos.pop_front());
    end
    for (int i = 0; i < pos.size(); i++) begin
      int lim;
      lim = (i == 0) ? ST : pos[i-1] - 1;
      pos[i] = (pos[i] + 1 < lim) ? pos[i] + 1 : lim;
    end
    if (acc) begin
      mq.push_back(cur);
      pos.push_back(1);
    end
    #1;
  endtask

  initial begin
    bit    acc;
    item_t basic;
    basic = '{x0: 8'h3C, x1: 8'h5A, x2: 8'hC3, y0: 8'hF0, y1: 8'h33, y2: 8'hCC,
              r0: 8'hFF, r1: 8'h00};
    last_q    = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive('0);
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_q", {8'd0, q2, q1, q0}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic operands: x=A5, y=0F.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(basic);
    cycle(acc);
    in_valid = 1'b0;
    for (int i = 0; i < ST - 1; i++) cycle(acc);
    chk("basic_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_xor", {24'd0, q0 ^ q1 ^ q2}, 32'h05);
`ifdef TI_AND_REFRESH_EN
    chk("basic_shares", {8'd0, q2, q1, q0}, {8'd0, 8'hF3, 8'h59, 8'hAF});
`else
    chk("basic_shares", {8'd0, q2, q1, q0}, {8'd0, 8'h0C, 8'h59, 8'h50});
`endif
    cycle(acc);

    // Throughput: 16 back-to-back items with the sink always ready.
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(rnd_item());
      cycle(acc);
    end
    in_valid = 1'b0;
    for (int i = 0; i < ST + 1; i++) cycle(acc);

    // Back-pressure: sink stalled, offer ST+1 items, then release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(rnd_item());
    for (int i = 0; i < ST + 3; i++) begin
      cycle(acc);
      if (acc) drive(rnd_item());
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle(acc);
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    for (int i = 0; i < ST + 1; i++) cycle(acc);

    // Non-completeness: only x2/y2 change, so share 0 must not move.
    for (int i = 0; i < 4; i++) begin
      item_t it;
      it    = basic;
      it.x2 = W'($urandom);
      it.y2 = W'($urandom);
      in_valid = 1'b1;
      drive(it);
      cycle(acc);
    end
    in_valid = 1'b0;
    for (int i = 0; i < ST; i++) begin
`ifdef TI_AND_REFRESH_EN
      if (out_valid) chk("noncomplete_q0", {24'd0, q0}, 32'hAF);
`else
      if (out_valid) chk("noncomplete_q0", {24'd0, q0}, 32'h50);
`endif
      cycle(acc);
    end

    // Reset with a full, stalled pipeline.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < ST; i++) begin
      drive(rnd_item());
      cycle(acc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_q", {8'd0, q2, q1, q0}, 32'd0);
    mq.delete();
    pos.delete();
    last_q   = '0;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(acc);

    // Random traffic with random stalls on both sides.
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        drive(rnd_item());
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < ST + 2; i++) cycle(acc);
    chk("drained_empty", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
